score_bcd_encoder: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3, one bit per cycle). Produces
//  the packed 4-bit decimal digits that feed the per-digit 7-segment decoders.

---
 rtl/score_bcd_encoder.sv | 117 +++++++++++
 tb/tb_score_bcd_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_encoder.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per cycle.
// Result registers only update on the FINISH edge so the display never sees partial sums.
module score_bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module score_bcd_encoder #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int          SW      = 4*DIGITS + 4;
  localparam int          CW      = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = 10**DIGITS - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [SW-1:0]       scr_q, scr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                ovf_c;

  // One adjuster per scratch digit, guard digit included.
  logic [DIGITS:0][3:0] adj;
  logic [SW-1:0]        adj_flat;
  assign adj_flat = adj;

  for (genvar g = 0; g <= DIGITS; g++) begin : g_dig
    score_bcd_add3 u_add3 (.din(scr_q[4*g +: 4]), .dout(adj[g]));
  end

  // Guard digit covers this config; the direct compare keeps wider BIN_W correct.
  assign ovf_c = (scr_q[SW-1 -: 4] != 4'd0) || (32'(bin_q) > MAX_VAL);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bin;
          bin_d   = bin;
          scr_d   = '0;
          cnt_d   = CW'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d   = {adj_flat[SW-2:0], shift_q[BIN_W-1]};
        shift_d = {shift_q[BIN_W-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FINISH;
      end
      FINISH: begin
        if (ovf_c) begin
          bcd_d = {DIGITS{4'h9}};
          ovf_d = 1'b1;
        end else begin
          bcd_d = scr_q[4*DIGITS-1:0];
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd      = bcd_q;
endmodule

// File: tb/tb_score_bcd_encoder.sv
// Randomized self-checking bench for score_bcd_encoder against a decimal-arithmetic model.
module tb_score_bcd_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        busy, done, overflow;
  logic [15:0] bcd;

  int errs = 0;
  int checks = 0;

  score_bcd_encoder #(.BIN_W(14), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .overflow(overflow), .bcd(bcd)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int x;
    if (v > 9999) return 16'h9999;
    r = '0;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit digits_ok(input logic [15:0] b);
    for (int d = 0; d < 4; d++) if (b[4*d +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Start one conversion from a negedge and watch a fixed 24-cycle window.
  // lat is counted in posedges after the accepting edge; -1 if no done seen.
  task automatic run_conv(input logic [13:0] v, input int pulse_at, input logic [13:0] pulse_bin,
                          output int lat, output int busy_n, output int dones, output bit held_ok);
    logic [15:0] pb;
    logic        po;
    bit          seen;
    pb = bcd; po = overflow;
    lat = -1; busy_n = 0; dones = 0; held_ok = 1'b1; seen = 1'b0;
    start = 1'b1; bin = v;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      start = 1'b0;
      bin = 14'($urandom);
      if (i == pulse_at) begin start = 1'b1; bin = pulse_bin; end
      if (busy) busy_n++;
      if (!digits_ok(bcd)) held_ok = 1'b0;
      if (done) begin
        dones++;
        if (!seen) lat = i - 1;
        seen = 1'b1;
      end else if (!seen && (bcd !== pb || overflow !== po)) held_ok = 1'b0;
    end
  endtask

  task automatic check_result(input string nm, input int v, input int lat, input int busy_n,
                              input int dones, input bit held_ok);
    checks++;
    if (lat !== 15 || busy_n !== 14 || dones !== 1) begin
      errs++;
      $display("FAIL %s timing: lat=%0d busy=%0d dones=%0d, need 15/14/1", nm, lat, busy_n, dones);
    end
    checks++;
    if (bcd !== ref_bcd(v) || overflow !== (v > 9999)) begin
      errs++;
      $display("FAIL %s value bin=%0d: bcd=%h ovf=%b, need %h/%b", nm, v, bcd, overflow,
               ref_bcd(v), v > 9999);
    end
    checks++;
    if (!held_ok) begin
      errs++;
      $display("FAIL %s hold: outputs changed early or invalid digit (got 0, need 1)", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bcd !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL reset: bcd=%h busy=%b done=%b ovf=%b, need 0000/0/0/0", bcd, busy, done, overflow);
    end
  endtask

  task automatic test_basic();
    int lat, bn, dn; bit ok;
    run_conv(14'd1234, 0, '0, lat, bn, dn, ok);
    check_result("basic_1234", 1234, lat, bn, dn, ok);
  endtask

  task automatic test_bounds();
    int lat, bn, dn; bit ok;
    int vals[4] = '{0, 9999, 10000, 16383};
    foreach (vals[i]) begin
      run_conv(14'(vals[i]), 0, '0, lat, bn, dn, ok);
      check_result("bound", vals[i], lat, bn, dn, ok);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bn, dn; bit ok;
    run_conv(14'd42, 5, 14'd77, lat, bn, dn, ok);
    check_result("ignore_start", 42, lat, bn, dn, ok);
  endtask

  task automatic test_reset_abort();
    int lat, bn, dn, nd; bit ok;
    start = 1'b1; bin = 14'd5678;
    for (int i = 1; i <= 7; i++) begin @(negedge clk); start = 1'b0; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bcd !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL abort_state: bcd=%h busy=%b done=%b ovf=%b, need 0000/0/0/0", bcd, busy, done, overflow);
    end
    nd = 0;
    repeat (20) begin @(negedge clk); if (done) nd++; end
    checks++;
    if (nd !== 0) begin
      errs++;
      $display("FAIL abort_nodone: dones=%0d, need 0", nd);
    end
    run_conv(14'd8, 0, '0, lat, bn, dn, ok);
    check_result("after_abort", 8, lat, bn, dn, ok);
  endtask

  task automatic test_back_to_back();
    int v[4];
    int k, last, gap_bad, seen;
    foreach (v[i]) v[i] = $urandom_range(0, 16383);
    v[1] = 9999;
    start = 1'b1; bin = 14'(v[0]);
    k = 1; last = -1; gap_bad = 0; seen = 0;
    for (int i = 1; i <= 70 && seen < 3; i++) begin
      @(negedge clk);
      if (done) begin
        checks++;
        if (bcd !== ref_bcd(v[seen]) || overflow !== (v[seen] > 9999)) begin
          errs++;
          $display("FAIL b2b[%0d] bin=%0d: bcd=%h ovf=%b, need %h/%b", seen, v[seen], bcd, overflow,
                   ref_bcd(v[seen]), v[seen] > 9999);
        end
        if (last >= 0 && i - last != 16) gap_bad++;
        last = i;
        seen++;
        k = seen;
      end
      bin = 14'(v[k]);
    end
    start = 1'b0;
    checks++;
    if (seen !== 3 || gap_bad !== 0) begin
      errs++;
      $display("FAIL b2b_rate: dones=%0d bad_gaps=%0d, need 3/0", seen, gap_bad);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bn, dn, v; bit ok;
    for (int n = 0; n < 10; n++) begin
      v = (n % 3 == 0) ? $urandom_range(9990, 10010) : $urandom_range(0, 16383);
      run_conv(14'(v), 0, '0, lat, bn, dn, ok);
      check_result("random", v, lat, bn, dn, ok);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_bounds();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
